// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops the receiver FIFO, decodes E0/F0 prefixes, tracks the held key.
// Optional macro PS2_TYPEMATIC_COUNT_EN makes typematic repeats pulse key_press and count too.
module ps2_key_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_ready,
    input  logic             fifo_overflow,
    input  logic             ovf_clr,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_valid,
    output logic             key_press,
    output logic [CNT_W-1:0] key_count,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

    state_t           state, state_nxt;
    logic             ext_pend, ext_pend_nxt;
    logic             brk_pend, brk_pend_nxt;
    logic [7:0]       key_code_nxt;
    logic             key_ext_nxt;
    logic             key_valid_nxt;
    logic             key_press_nxt;
    logic [CNT_W-1:0] key_count_nxt;
    logic             nextdata_n_nxt;
    logic             is_held;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt     = state;
        ext_pend_nxt  = ext_pend;
        brk_pend_nxt  = brk_pend;
        key_code_nxt  = key_code;
        key_ext_nxt   = key_ext;
        key_valid_nxt = key_valid;
        key_press_nxt = 1'b0;
        key_count_nxt = key_count;
        is_held       = key_valid && (fifo_data == key_code) && (ext_pend == key_ext);

        case (state)
            IDLE: begin
                if (fifo_ready) begin
                    state_nxt = POP;
                    if (fifo_data == 8'hE0) begin
                        ext_pend_nxt = 1'b1;
                    end else if (fifo_data == 8'hF0) begin
                        brk_pend_nxt = 1'b1;
                    end else begin
                        ext_pend_nxt = 1'b0;
                        brk_pend_nxt = 1'b0;
                        if (brk_pend) begin
                            // A break only releases the exact key (code and extension) being held.
                            if (is_held)
                                key_valid_nxt = 1'b0;
                        end else if (!is_held) begin
                            key_code_nxt  = fifo_data;
                            key_ext_nxt   = ext_pend;
                            key_valid_nxt = 1'b1;
                            key_press_nxt = 1'b1;
                            key_count_nxt = key_count + CNT_W'(1);
                        end
`ifdef PS2_TYPEMATIC_COUNT_EN
                        else begin
                            key_press_nxt = 1'b1;
                            key_count_nxt = key_count + CNT_W'(1);
                        end
`endif
                    end
                end
            end
            POP:     state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Pop strobe is registered: low exactly while the FSM sits in POP.
        nextdata_n_nxt = (state_nxt != POP);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_valid  <= 1'b0;
            key_press  <= 1'b0;
            key_count  <= '0;
        end else begin
            state      <= state_nxt;
            nextdata_n <= nextdata_n_nxt;
            ext_pend   <= ext_pend_nxt;
            brk_pend   <= brk_pend_nxt;
            key_code   <= key_code_nxt;
            key_ext    <= key_ext_nxt;
            key_valid  <= key_valid_nxt;
            key_press  <= key_press_nxt;
            key_count  <= key_count_nxt;
        end
    end

    // Set has priority over clear so an overflow coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (fifo_overflow)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end

endmodule
